// File: rtl/seq_checker.sv
// seq_checker: tracks an incrementing beat stream from an upstream
// enable-gated up-counter. It locks after LOCK_N consecutive in-sequence
// beats (seed included) and counts sequence breaks that occur while locked.
module seq_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_N    = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected,
    output logic [15:0]          rx_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ERR    = 2'd3
    } state_t;

    // LOCK_N is at most 15, so a 4-bit run counter is always wide enough.
    localparam logic [3:0]           LOCK_RUN = 4'(LOCK_N);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    state_t               state_r;
    logic [3:0]           run_r;
    logic [WIDTH-1:0]     expected_r;
    logic                 in_ready_r;
    logic                 locked_r;
    logic                 err_pulse_r;
    logic [ERR_CNT_W-1:0] err_count_r;
    logic [15:0]          rx_count_r;

    logic                 accept_s;
    logic                 match_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
        logic [ERR_CNT_W-1:0] res;
        if (val == ERR_MAX) begin
            res = val;
        end else begin
            res = val + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // A beat offered together with clr is ignored entirely.
    assign accept_s = in_valid & in_ready_r & ~clr;
    assign match_s  = (in_data == expected_r);

    assign in_ready  = in_ready_r;
    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;
    assign expected  = expected_r;
    assign rx_count  = rx_count_r;

    // Sequence-tracking FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            run_r       <= 4'd0;
            expected_r  <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= {ERR_CNT_W{1'b0}};
            rx_count_r  <= 16'd0;
        end else if (clr) begin
            state_r     <= IDLE;
            run_r       <= 4'd0;
            expected_r  <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else begin
            err_pulse_r <= 1'b0;
            if (accept_s) begin
                rx_count_r <= rx_count_r + 16'd1;
            end
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        expected_r <= in_data + WIDTH'(1);
                        run_r      <= 4'd1;
                        state_r    <= SYNC;
                    end
                end
                SYNC: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        if (match_s) begin
                            expected_r <= expected_r + WIDTH'(1);
                            run_r      <= run_r + 4'd1;
                            if ((run_r + 4'd1) == LOCK_RUN) begin
                                state_r  <= LOCKED;
                                locked_r <= 1'b1;
                            end
                        end else begin
                            // Still acquiring: a break just restarts the run.
                            expected_r <= in_data + WIDTH'(1);
                            run_r      <= 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (accept_s) begin
                        if (match_s) begin
                            expected_r <= expected_r + WIDTH'(1);
                        end else begin
                            err_pulse_r <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            locked_r    <= 1'b0;
                            expected_r  <= in_data + WIDTH'(1);
                            run_r       <= 4'd1;
                            in_ready_r  <= 1'b0;
                            state_r     <= ERR;
                        end
                    end
                end
                ERR: begin
                    // One stall cycle, then resume acquisition from the reseed.
                    in_ready_r <= 1'b1;
                    state_r    <= SYNC;
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                    locked_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed-vector bench for seq_checker with hand-computed
// expectations. A second instance with a 2-bit error counter shares the
// stimulus to exercise saturation.
module tb_seq_checker;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [3:0]  expected;
    logic [15:0] rx_count;

    logic        d2_in_ready;
    logic        d2_locked;
    logic        d2_err_pulse;
    logic [1:0]  d2_err_count;
    logic [3:0]  d2_expected;
    logic [15:0] d2_rx_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rx   = 0;

    seq_checker dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected),
        .rx_count  (rx_count)
    );

    seq_checker #(.ERR_CNT_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (d2_in_ready),
        .locked    (d2_locked),
        .err_pulse (d2_err_pulse),
        .err_count (d2_err_count),
        .expected  (d2_expected),
        .rx_count  (d2_rx_count)
    );

    // Clock: rising edges at 7, 17, 27, ...
    initial begin
        clk = 1'b0;
        #2;
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, req);
        end
    endtask

    task automatic beat(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        exp_rx++;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr(input logic [3:0] d);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'h5;

        // Reset held with a beat offered: outputs stay at reset values.
        #1;
        check_val("rst_ready",  32'(in_ready),  32'd1);
        check_val("rst_locked", 32'(locked),    32'd0);
        check_val("rst_pulse",  32'(err_pulse), 32'd0);
        check_val("rst_errcnt", 32'(err_count), 32'd0);
        check_val("rst_exp",    32'(expected),  32'd0);
        check_val("rst_rx",     32'(rx_count),  32'd0);
        #7;
        check_val("rst_edge_exp", 32'(expected), 32'd0);
        check_val("rst_edge_rx",  32'(rx_count), 32'd0);
        #7;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_rx++;
        in_valid = 1'b0;
        check_val("seed_exp",    32'(expected), 32'd6);
        check_val("seed_rx",     32'(rx_count), 32'(exp_rx));
        check_val("seed_locked", 32'(locked),   32'd0);

        // clr with a simultaneous beat 7: ignored, then 7 seeds.
        do_clr(4'h7);
        check_val("clr_exp",    32'(expected),  32'd0);
        check_val("clr_errcnt", 32'(err_count), 32'd0);
        check_val("clr_rx",     32'(rx_count),  32'(exp_rx));
        beat(4'h7);
        check_val("clr_seed_exp", 32'(expected), 32'd8);
        check_val("clr_seed_rx",  32'(rx_count), 32'(exp_rx));

        // Lock on 3,4,5.
        do_clr(4'h0);
        beat(4'h3);
        beat(4'h4);
        check_val("pre_lock", 32'(locked), 32'd0);
        beat(4'h5);
        check_val("lock",        32'(locked),    32'd1);
        check_val("lock_exp",    32'(expected),  32'd6);
        check_val("lock_errcnt", 32'(err_count), 32'd0);
        check_val("lock_rx",     32'(rx_count),  32'(exp_rx));

        // Break while locked: 9 instead of 6.
        beat(4'h9);
        check_val("brk_pulse",  32'(err_pulse), 32'd1);
        check_val("brk_errcnt", 32'(err_count), 32'd1);
        check_val("brk_locked", 32'(locked),    32'd0);
        check_val("brk_ready",  32'(in_ready),  32'd0);
        // Beat offered during the stall cycle must not be accepted.
        in_valid = 1'b1;
        in_data  = 4'h3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("err_ready", 32'(in_ready),  32'd1);
        check_val("err_pulse", 32'(err_pulse), 32'd0);
        check_val("err_exp",   32'(expected),  32'hA);
        check_val("err_rx",    32'(rx_count),  32'(exp_rx));
        beat(4'hA);
        beat(4'hB);
        check_val("relock",     32'(locked),   32'd1);
        check_val("relock_exp", 32'(expected), 32'hC);

        // Wrap through all-ones while locked.
        beat(4'hC);
        beat(4'hD);
        beat(4'hE);
        beat(4'hF);
        check_val("wrap_exp0", 32'(expected), 32'h0);
        beat(4'h0);
        beat(4'h1);
        check_val("wrap_exp",    32'(expected),  32'h2);
        check_val("wrap_locked", 32'(locked),    32'd1);
        check_val("wrap_pulse",  32'(err_pulse), 32'd0);
        check_val("wrap_errcnt", 32'(err_count), 32'd1);

        // Idle cycles change nothing.
        idle_cycle();
        idle_cycle();
        check_val("idle_exp", 32'(expected), 32'h2);
        check_val("idle_rx",  32'(rx_count), 32'(exp_rx));

        // Mismatch during acquisition reseeds silently.
        do_clr(4'h0);
        beat(4'h3);
        beat(4'h7);
        check_val("sync_rs_exp",    32'(expected),  32'h8);
        check_val("sync_rs_errcnt", 32'(err_count), 32'd0);
        check_val("sync_rs_pulse",  32'(err_pulse), 32'd0);
        beat(4'h8);
        check_val("sync_rs_nolock", 32'(locked), 32'd0);
        beat(4'h9);
        check_val("sync_rs_lock", 32'(locked), 32'd1);

        // Five locked-state breaks: 8-bit counter reaches 5, 2-bit saturates at 3.
        do_clr(4'h0);
        for (int i = 0; i < 5; i++) begin
            beat(4'(4 * i));
            beat(4'(4 * i + 1));
            beat(4'(4 * i + 2));
            beat(4'(4 * i + 5));
            idle_cycle();
            if (i >= 2) begin
                check_val("sat_cnt2", 32'(d2_err_count), 32'd3);
            end
        end
        check_val("sat_cnt8", 32'(err_count), 32'd5);
        check_val("sat_rx",   32'(rx_count),  32'(exp_rx));

        // Mid-stream asynchronous reset, then a fresh seed.
        beat(4'h1);
        beat(4'h2);
        beat(4'h3);
        check_val("pre_arst_lock", 32'(locked), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        exp_rx = 0;
        check_val("arst_locked", 32'(locked),   32'd0);
        check_val("arst_exp",    32'(expected), 32'd0);
        check_val("arst_rx",     32'(rx_count), 32'd0);
        check_val("arst_errcnt", 32'(err_count), 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        beat(4'h9);
        check_val("arst_seed_exp",  32'(expected), 32'hA);
        check_val("arst_seed_lock", 32'(locked),   32'd0);
        check_val("arst_seed_rx",   32'(rx_count), 32'(exp_rx));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the data beat.
REQ-002 SHALL have parameter LOCK_N, default 3: number of consecutive in-sequence beats, counting the seed beat, needed to lock; legal range 2..15.
REQ-003 SHALL have parameter ERR_CNT_W, default 8: width of the error counter.
REQ-004 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of the error counter and sequence state.
REQ-007 SHALL have port in_valid  input  1  a beat is offered on in_data.
REQ-008 SHALL have port in_data  input  WIDTH  beat value from the upstream enable-gated up-counter.
REQ-009 SHALL have port in_ready  output  1  the checker can accept a beat.
REQ-010 SHALL have port locked  output  1  the incoming stream is tracked as an incrementing sequence.
REQ-011 SHALL have port err_pulse  output  1  one-cycle flag for a sequence break seen while locked.
REQ-012 SHALL have port err_count  output  ERR_CNT_W  saturating count of sequence breaks.
REQ-013 SHALL have port expected  output  WIDTH  next in_data value the checker expects.
REQ-014 SHALL have port rx_count  output  16  count of accepted beats; wraps modulo 2^16.

Function
REQ-015 A beat SHALL be accepted only when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-016 All outputs SHALL be registered; every response appears in the cycle after the edge that caused it.
REQ-017 The FSM SHALL have four states: IDLE, SYNC, LOCKED, ERR.
REQ-018 In IDLE, an accepted beat SHALL seed the checker: expected=in_data+1, run=1, next state SYNC.
REQ-019 In SYNC, an accepted beat with in_data==expected SHALL do run+1 and expected+1.
REQ-020 In SYNC, when run reaches LOCK_N the next state SHALL be LOCKED and locked SHALL be 1.
REQ-021 In SYNC, an accepted beat with in_data!=expected SHALL reseed (expected=in_data+1, run=1), with no error and no change to err_count.
REQ-022 In LOCKED, a matching accepted beat SHALL do expected+1 and stay in LOCKED.
REQ-023 In LOCKED, a mismatching accepted beat SHALL set err_pulse=1 for exactly one cycle, increment err_count, clear locked, reseed from in_data (expected=in_data+1, run=1) and enter ERR.
REQ-024 ERR SHALL last exactly one cycle with in_ready=0 and then go to SYNC.
REQ-025 in_ready SHALL be 1 in every state except ERR.
REQ-026 All expected arithmetic SHALL be modulo 2^WIDTH, so the value after all-ones is 0 and is not an error.
REQ-027 err_count SHALL saturate at 2^ERR_CNT_W-1 and never wrap.
REQ-028 rx_count SHALL increment on every accepted beat in every state except during clr.
REQ-029 Cycles with in_valid=0 SHALL change no state, counter or expected value.
REQ-030 clr=1 SHALL, at the next edge, force IDLE, locked=0, err_count=0, err_pulse=0, run=0 and expected=0; rx_count is unchanged.
REQ-031 A beat offered in the same cycle as clr=1 SHALL be ignored: not accepted, not counted, not checked.

Reset
REQ-032 Asserting reset SHALL immediately, without waiting for clk, force IDLE, in_ready=1, locked=0, err_pulse=0, err_count=0, expected=0, rx_count=0, run=0.
REQ-033 A reset asserted mid-stream SHALL discard all tracking; the first accepted beat after release SHALL act as a new seed.
REQ-034 Reset SHALL take priority over clr and over all beats.

Verification
REQ-035 reset=1 for 15 time units with in_valid=1 -> all outputs at reset values throughout; first beat after release is a seed.
REQ-036 Beats 3,4,5 on consecutive cycles -> locked=1 in the cycle after beat 5, expected=6, err_count=0, rx_count=3.
REQ-037 When locked, beats E,F,0,1 -> no err_pulse, expected=2, locked stays 1.
REQ-038 When locked with expected=6, beat 9 -> next cycle err_pulse=1, err_count=1, locked=0, in_ready=0; one cycle later in_ready=1 and expected=A; then beats A,B -> locked=1.
REQ-039 With ERR_CNT_W=2, force 5 locked-state breaks -> err_count reaches 3 and holds at 3.
REQ-040 clr=1 with in_valid=1 and in_data=7 in the same cycle -> IDLE, err_count=0, rx_count unchanged; the next beat 7 seeds with expected=8.
